// File: rtl/power_monitor_pkg.sv
// rtl/power_monitor_pkg.sv - shared types and helpers for the multi-channel power monitor
//
// Purpose: FSM state encoding, sample-type encoding and the helper that
// locates a channel's slice inside the packed per-channel buses.
// Ports: none (package).
package power_monitor_pkg;

  // Default ADC sample width; each channel occupies one slice of this width.
  localparam int ADC_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_CONVERT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  typedef enum logic {
    SAMPLE_CW   = 1'b0,
    SAMPLE_PEAK = 1'b1
  } sample_type_t;

  // LSB position of channel ch in a bus packed as ch*width +: width.
  function automatic int ch_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/adc_limit_check.sv
// rtl/adc_limit_check.sv - per-channel ADC shift register, value store and limit filter
//
// Purpose: deserialises one ADC channel, keeps the latest/peak/CW samples and
// runs the consecutive-exceed filter for both sample types.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   shift_en, sdo       capture one serial bit (MSB first)
//   load                transfer shift register into the value registers
//   check_en, is_peak   evaluate limits for the freshly loaded sample and its type
//   clear               clear fail flags and exceed counters
//   peak_limit/cw_limit per-type limits (unsigned, strict greater-than trips)
//   sample_value, peak_value, cw_value   stored samples
//   peak_fail, cw_fail  sticky fail flags
module adc_limit_check
  import power_monitor_pkg::*;
#(
  parameter int DATA_W     = ADC_DATA_W,
  parameter int FAIL_COUNT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              sdo,
  input  logic              load,
  input  logic              check_en,
  input  logic              is_peak,
  input  logic              clear,
  input  logic [DATA_W-1:0] peak_limit,
  input  logic [DATA_W-1:0] cw_limit,
  output logic [DATA_W-1:0] sample_value,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] cw_value,
  output logic              peak_fail,
  output logic              cw_fail
);

  localparam int CNT_W = $clog2(FAIL_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FAIL_COUNT);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(FAIL_COUNT - 1);

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  peak_cnt;
  logic [CNT_W-1:0]  cw_cnt;
  logic              peak_exceed;
  logic              cw_exceed;

  // Limit 0 has no special meaning: any nonzero sample exceeds it.
  assign peak_exceed = sample_value > peak_limit;
  assign cw_exceed   = sample_value > cw_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[DATA_W-2:0], sdo};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_value <= '0;
      peak_value   <= '0;
      cw_value     <= '0;
    end else if (load) begin
      sample_value <= shift_q;
      if (is_peak) begin
        peak_value <= shift_q;
      end else begin
        cw_value <= shift_q;
      end
    end
  end

  // clear is applied first so a same-cycle check result overrides it: a trip
  // on the clearing cycle leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_cnt  <= '0;
      cw_cnt    <= '0;
      peak_fail <= 1'b0;
      cw_fail   <= 1'b0;
    end else begin
      if (clear) begin
        peak_cnt  <= '0;
        cw_cnt    <= '0;
        peak_fail <= 1'b0;
        cw_fail   <= 1'b0;
      end
      if (check_en) begin
        if (is_peak) begin
          if (peak_exceed) begin
            peak_cnt <= (peak_cnt == CNT_MAX) ? peak_cnt : peak_cnt + 1'b1;
            if (peak_cnt >= CNT_TRIP) begin
              peak_fail <= 1'b1;
            end
          end else begin
            peak_cnt <= '0;
          end
        end else begin
          if (cw_exceed) begin
            cw_cnt <= (cw_cnt == CNT_MAX) ? cw_cnt : cw_cnt + 1'b1;
            if (cw_cnt >= CNT_TRIP) begin
              cw_fail <= 1'b1;
            end
          end else begin
            cw_cnt <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/multi_channel_power_monitor.sv
// rtl/multi_channel_power_monitor.sv - multi-channel laser PEAK/CW power monitor with safety flags
//
// Purpose: sequences shared convert/SCK to NUM_CH serial ADCs, tags each sample
// set PEAK (pulse-triggered) or CW (periodic), and latches sticky fail flags.
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   laser_pulse           asynchronous pulse input (synchronised here)
//   clear_fail            clear sticky flags, exceed counters and missed_pulse
//   adc_sdo               serial data, one bit per channel
//   adc_sck, adc_convert  shared ADC serial clock (idle low) and convert strobe
//   peak_limit, cw_limit  packed per-channel limits
//   sample_valid, sample_is_peak, sample_value  latest sample set and its type
//   peak_value, cw_value  last PEAK / CW sample per channel
//   peak_fail, cw_fail, missed_pulse, any_fail  safety status
module multi_channel_power_monitor
  import power_monitor_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = ADC_DATA_W,
  parameter int SCK_DIV     = 2,
  parameter int CONV_CYCLES = 40,
  parameter int PULSE_DELAY = 20,
  parameter int CW_PERIOD   = 5000,
  parameter int FAIL_COUNT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     laser_pulse,
  input  logic                     clear_fail,
  input  logic [NUM_CH-1:0]        adc_sdo,
  output logic                     adc_sck,
  output logic                     adc_convert,
  input  logic [NUM_CH*DATA_W-1:0] peak_limit,
  input  logic [NUM_CH*DATA_W-1:0] cw_limit,
  output logic                     sample_valid,
  output logic                     sample_is_peak,
  output logic [NUM_CH*DATA_W-1:0] sample_value,
  output logic [NUM_CH*DATA_W-1:0] peak_value,
  output logic [NUM_CH*DATA_W-1:0] cw_value,
  output logic [NUM_CH-1:0]        peak_fail,
  output logic [NUM_CH-1:0]        cw_fail,
  output logic                     missed_pulse,
  output logic                     any_fail
);

  localparam int PH_MAX = (PULSE_DELAY > CONV_CYCLES) ? PULSE_DELAY : CONV_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int SCK_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW_W   = (CW_PERIOD > 1) ? $clog2(CW_PERIOD) : 1;

  localparam logic [PH_W-1:0]  DELAY_LAST = PH_W'(PULSE_DELAY - 1);
  localparam logic [PH_W-1:0]  CONV_LAST  = PH_W'(CONV_CYCLES - 1);
  localparam logic [SCK_W-1:0] SCK_LAST   = SCK_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);
  localparam logic [CW_W-1:0]  CW_LAST    = CW_W'(CW_PERIOD - 1);

  state_t       state_q, state_d;
  sample_type_t type_q;
  logic [2:0]       sync_q;
  logic             pulse_sync, pulse_rise;
  logic             pending_q;
  logic [CW_W-1:0]  cw_timer;
  logic             cw_due;
  logic [PH_W-1:0]  phase_cnt;
  logic [SCK_W-1:0] sck_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             sck_tick, capture, load, edge_busy;
  logic             start_peak, start_cw;

  // sync_q[0..1] is the two-flop synchroniser; sync_q[2] delays for edge detect.
  assign pulse_sync = sync_q[1];
  assign pulse_rise = sync_q[1] & ~sync_q[2];
  assign cw_due     = (cw_timer == CW_LAST) && !pulse_sync;
  assign sck_tick   = (sck_cnt == SCK_LAST);
  assign capture    = (state_q == ST_SHIFT) && !adc_sck && sck_tick;
  assign load       = (state_q == ST_SHIFT) && (state_d == ST_DONE);
  assign edge_busy  = pulse_rise && (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    start_peak = 1'b0;
    start_cw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pulse_rise || pending_q) begin
          state_d    = ST_DELAY;
          start_peak = 1'b1;
        end else if (cw_due) begin
          state_d  = ST_CONVERT;
          start_cw = 1'b1;
        end
      end
      ST_DELAY:   if (phase_cnt == DELAY_LAST) state_d = ST_CONVERT;
      ST_CONVERT: if (phase_cnt == CONV_LAST) state_d = ST_SHIFT;
      // Leave on the falling SCK edge that ends the last bit.
      ST_SHIFT:   if (adc_sck && sck_tick && (bit_cnt == BIT_LAST)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      type_q    <= SAMPLE_CW;
      phase_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (start_peak) begin
        type_q <= SAMPLE_PEAK;
      end else if (start_cw) begin
        type_q <= SAMPLE_CW;
      end
      if (state_d != state_q) begin
        phase_cnt <= '0;
      end else if ((state_q == ST_DELAY) || (state_q == ST_CONVERT)) begin
        phase_cnt <= phase_cnt + 1'b1;
      end
    end
  end

  // SCK: SCK_DIV clk low then SCK_DIV clk high per bit; bit_cnt steps on the fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_sck     <= 1'b0;
      sck_cnt     <= '0;
      bit_cnt     <= '0;
      adc_convert <= 1'b0;
    end else begin
      adc_convert <= (state_d == ST_CONVERT);
      if (state_q == ST_SHIFT) begin
        if (sck_tick) begin
          sck_cnt <= '0;
          adc_sck <= ~adc_sck;
          if (adc_sck) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else begin
          sck_cnt <= sck_cnt + 1'b1;
        end
      end else begin
        adc_sck <= 1'b0;
        sck_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      cw_timer <= '0;
    end else begin
      sync_q <= {sync_q[1:0], laser_pulse};
      if (pulse_sync || start_peak || start_cw) begin
        cw_timer <= '0;
      end else if (cw_timer != CW_LAST) begin
        // Saturates so a CW sample due during an acquisition runs right after it.
        cw_timer <= cw_timer + 1'b1;
      end
    end
  end

  // One-deep pending slot for edges arriving while busy. When IDLE starts on
  // the pending flag and a fresh edge lands the same cycle, the slot stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      missed_pulse <= 1'b0;
    end else begin
      if (clear_fail) begin
        missed_pulse <= 1'b0;
      end
      if (edge_busy) begin
        if (pending_q) begin
          missed_pulse <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end else if (start_peak) begin
        pending_q <= pending_q & pulse_rise;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_valid   <= 1'b0;
      sample_is_peak <= 1'b0;
      any_fail       <= 1'b0;
    end else begin
      sample_valid <= load;
      if (load) begin
        sample_is_peak <= (type_q == SAMPLE_PEAK);
      end
      any_fail <= (|peak_fail) | (|cw_fail) | missed_pulse;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_limit_check #(
      .DATA_W    (DATA_W),
      .FAIL_COUNT(FAIL_COUNT)
    ) u_check (
      .clk         (clk),
      .rst         (rst),
      .shift_en    (capture),
      .sdo         (adc_sdo[i]),
      .load        (load),
      .check_en    (state_q == ST_DONE),
      .is_peak     (type_q == SAMPLE_PEAK),
      .clear       (clear_fail),
      .peak_limit  (peak_limit[ch_lsb(i, DATA_W) +: DATA_W]),
      .cw_limit    (cw_limit[ch_lsb(i, DATA_W) +: DATA_W]),
      .sample_value(sample_value[ch_lsb(i, DATA_W) +: DATA_W]),
      .peak_value  (peak_value[ch_lsb(i, DATA_W) +: DATA_W]),
      .cw_value    (cw_value[ch_lsb(i, DATA_W) +: DATA_W]),
      .peak_fail   (peak_fail[i]),
      .cw_fail     (cw_fail[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_power_monitor.sv
// tb/tb_multi_channel_power_monitor.sv - directed self-checking bench for multi_channel_power_monitor
module tb_multi_channel_power_monitor;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 16;
  localparam int SCK_DIV     = 2;
  localparam int CONV_CYCLES = 40;
  localparam int PULSE_DELAY = 20;
  localparam int CW_PERIOD   = 1000;
  localparam int FAIL_COUNT  = 2;

  // Raw pulse set between edges -> sample_valid seen after this many posedges.
  localparam int LAT_PEAK = 2 + PULSE_DELAY + CONV_CYCLES + 2 * SCK_DIV * DATA_W + 1;
  // From reset release: timer hits CW_PERIOD-1 after CW_PERIOD-1 edges, then CW latency.
  localparam int LAT_CW_RST = (CW_PERIOD - 1) + CONV_CYCLES + 2 * SCK_DIV * DATA_W + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     laser_pulse = 1'b0;
  logic                     clear_fail = 1'b0;
  logic [NUM_CH-1:0]        adc_sdo = '0;
  logic                     adc_sck;
  logic                     adc_convert;
  logic [NUM_CH*DATA_W-1:0] peak_limit = '1;
  logic [NUM_CH*DATA_W-1:0] cw_limit = '1;
  logic                     sample_valid;
  logic                     sample_is_peak;
  logic [NUM_CH*DATA_W-1:0] sample_value;
  logic [NUM_CH*DATA_W-1:0] peak_value;
  logic [NUM_CH*DATA_W-1:0] cw_value;
  logic [NUM_CH-1:0]        peak_fail;
  logic [NUM_CH-1:0]        cw_fail;
  logic                     missed_pulse;
  logic                     any_fail;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_channel_power_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SCK_DIV(SCK_DIV), .CONV_CYCLES(CONV_CYCLES),
    .PULSE_DELAY(PULSE_DELAY), .CW_PERIOD(CW_PERIOD), .FAIL_COUNT(FAIL_COUNT)
  ) dut (
    .clk(clk), .rst(rst), .laser_pulse(laser_pulse), .clear_fail(clear_fail),
    .adc_sdo(adc_sdo), .adc_sck(adc_sck), .adc_convert(adc_convert),
    .peak_limit(peak_limit), .cw_limit(cw_limit),
    .sample_valid(sample_valid), .sample_is_peak(sample_is_peak),
    .sample_value(sample_value), .peak_value(peak_value), .cw_value(cw_value),
    .peak_fail(peak_fail), .cw_fail(cw_fail),
    .missed_pulse(missed_pulse), .any_fail(any_fail)
  );

  // ADC model: latch word at convert start, present MSB, next bit on each SCK fall.
  logic [DATA_W-1:0] adc_word   [NUM_CH];
  logic [DATA_W-1:0] adc_shadow [NUM_CH];
  int adc_bit = 0;

  always @(posedge adc_convert or negedge adc_sck) begin
    if (adc_convert) begin
      for (int i = 0; i < NUM_CH; i++) adc_shadow[i] = adc_word[i];
      adc_bit = DATA_W - 1;
    end else if (adc_bit > 0) begin
      adc_bit = adc_bit - 1;
    end
    for (int i = 0; i < NUM_CH; i++) adc_sdo[i] = adc_shadow[i][adc_bit];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    adc_word[0] = w0; adc_word[1] = w1; adc_word[2] = w2; adc_word[3] = w3;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (sample_valid) begin
        n = k;
        break;
      end
    end
  endtask

  // Raise laser_pulse between edges, drop it after 4 edges, return edges to sample_valid.
  task automatic pulse_timed(output int n);
    @(negedge clk);
    laser_pulse = 1'b1;
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (k == 4) laser_pulse = 1'b0;
      if (sample_valid) begin
        n = k;
        break;
      end
    end
    laser_pulse = 1'b0;
  endtask

  task automatic pulse(input int hi);
    @(negedge clk);
    laser_pulse = 1'b1;
    repeat (hi) @(negedge clk);
    laser_pulse = 1'b0;
  endtask

  task automatic count_valids(input int cycles, output int n_all, output int n_peak);
    n_all = 0;
    n_peak = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (sample_valid) begin
        n_all++;
        if (sample_is_peak) n_peak++;
      end
    end
  endtask

  task automatic clear_idle();
    @(negedge clk);
    clear_fail = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0;
    tick();
  endtask

  initial begin
    int n, na, np, rises;
    logic prev_sck;

    set_words(16'h0200, 16'h0050, 16'h0050, 16'h0050);
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", 64'(adc_sck), 64'd0);
    check("rst_convert", 64'(adc_convert), 64'd0);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_flags", 64'({missed_pulse, any_fail, peak_fail, cw_fail}), 64'd0);
    check("rst_sample", sample_value, 64'd0);

    // CW: ch0 limit 0x0100, sample 0x0200, two CW samples needed to trip.
    cw_limit[15:0] = 16'h0100;
    @(negedge clk) rst = 1'b0;
    wait_valid(CW_PERIOD + 200, n);
    check("cw1_latency", 64'(n), 64'(LAT_CW_RST));
    check("cw1_type", 64'(sample_is_peak), 64'd0);
    check("cw1_value", 64'(sample_value[15:0]), 64'h0200);
    tick();
    check("cw1_no_trip", 64'(cw_fail), 64'd0);
    wait_valid(CW_PERIOD + 200, n);
    check("cw2_period", 64'(n), 64'(CW_PERIOD - 1));
    check("cw2_type", 64'(sample_is_peak), 64'd0);
    tick();
    check("cw2_trip", 64'(cw_fail), 64'b0001);
    check("cw_peak_unchanged", peak_value, 64'd0);
    check("cw_value", cw_value, {16'h0050, 16'h0050, 16'h0050, 16'h0200});
    tick();
    check("cw_any_fail", 64'(any_fail), 64'd1);

    // Fresh start so the CW timer is far from due during the peak tests.
    @(negedge clk) rst = 1'b1;
    cw_limit = '1;
    @(negedge clk) rst = 1'b0;
    check("rst2_cw_fail", 64'(cw_fail), 64'd0);

    set_words(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    pulse_timed(n);
    check("peak_latency", 64'(n), 64'(LAT_PEAK));
    check("peak_type", 64'(sample_is_peak), 64'd1);
    check("peak_value", peak_value, {4{16'h1234}});
    check("peak_cw_unchanged", cw_value, 64'd0);
    tick();

    // Ch2 limit 0x1000: two consecutive 0x1001 trip, not one.
    peak_limit[32 +: 16] = 16'h1000;
    adc_word[2] = 16'h1001;
    pulse_timed(n);
    tick();
    check("fc_first_no_trip", 64'(peak_fail), 64'd0);
    pulse_timed(n);
    tick();
    check("fc_second_trip", 64'(peak_fail), 64'b0100);
    tick();
    check("fc_any_fail", 64'(any_fail), 64'd1);
    clear_idle();
    check("fc_clear_flags", 64'(peak_fail), 64'd0);
    check("fc_clear_any", 64'(any_fail), 64'd0);

    adc_word[2] = 16'h1001;
    pulse_timed(n);
    adc_word[2] = 16'h0FFF;
    pulse_timed(n);
    adc_word[2] = 16'h1001;
    pulse_timed(n);
    tick();
    check("pattern_no_trip", 64'(peak_fail), 64'd0);
    check("pattern_ch2", 64'(sample_value[32 +: 16]), 64'h1001);

    // Trip on the same cycle as clear_fail: trip wins.
    pulse_timed(n);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("clr_same_cycle_trip", 64'(peak_fail), 64'b0100);
    tick();
    check("clr_same_cycle_any", 64'(any_fail), 64'd1);
    clear_idle();
    check("clr_later_flags", 64'(peak_fail), 64'd0);
    check("clr_later_any", 64'(any_fail), 64'd0);

    // Three edges inside one acquisition.
    peak_limit = '1;
    set_words(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    pulse(3);
    repeat (4) @(negedge clk);
    pulse(3);
    repeat (4) @(negedge clk);
    pulse(3);
    count_valids(400, na, np);
    check("miss_valids", 64'(na), 64'd2);
    check("miss_peaks", 64'(np), 64'd2);
    check("missed_pulse", 64'(missed_pulse), 64'd1);
    check("miss_any_fail", 64'(any_fail), 64'd1);
    clear_idle();
    check("miss_cleared", 64'({missed_pulse, any_fail}), 64'd0);

    // Reset while the eighth bit (bit 7) is being clocked.
    set_words(16'hA5A5, 16'h5A5A, 16'h0F0F, 16'hF0F0);
    pulse(3);
    rises = 0;
    prev_sck = 1'b0;
    for (int k = 0; k < 300 && rises < 8; k++) begin
      tick();
      if (adc_sck && !prev_sck) rises++;
      prev_sck = adc_sck;
    end
    check("rst_mid_sck_rises", 64'(rises), 64'd8);
    check("rst_mid_sck_before", 64'(adc_sck), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_sck", 64'(adc_sck), 64'd0);
    check("rst_mid_convert", 64'(adc_convert), 64'd0);
    @(negedge clk) rst = 1'b0;
    count_valids(300, na, np);
    check("rst_mid_no_valid", 64'(na), 64'd0);
    pulse_timed(n);
    check("rst_after_latency", 64'(n), 64'(LAT_PEAK));
    check("rst_after_value", peak_value, {16'hF0F0, 16'h0F0F, 16'h5A5A, 16'hA5A5});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
